fread_bridge: RTL and testbench
===============================

# fread_bridge

ESP-facing front end for chunked file loads. It accepts one read request (32-bit byte offset) per chunk from the SPRAM loader, raises an interrupt to the ESP, and serves a 10-byte request descriptor over the SPI protocol-wrapper read path. It then forwards the ESP's data bytes to the loader as a `resp_data`/`resp_valid` byte stream. It sits between the protocol wrapper (SPI slave) and the SPRAM loader; the wrapper's `pw_end` is also routed to the loader.

## Interface
- `FILE_ID`, 32'hDABBAD00, file identifier reported in the descriptor
- `CHUNK_LEN`, 16'h0800, bytes requested per chunk; data bytes beyond this per request are dropped
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  1  loader request; held until accepted
- `req_ready`  out  1  high only in IDLE; a request is accepted on `req_valid & req_ready`
- `req_offset`  in  32  byte offset, sampled on acceptance
- `resp_data`  out  8  data byte to loader
- `resp_valid`  out  1  one-cycle strobe per forwarded byte
- `pw_wdata`  in  8  wrapper write byte
- `pw_wcmd`  in  1  qualifies `pw_wdata` as a command byte
- `pw_wstb`  in  1  write byte strobe
- `pw_end`  in  1  end of the current SPI transaction (one-cycle pulse)
- `pw_rdata`  out  8  read byte to wrapper
- `pw_rstb`  in  1  wrapper has consumed `pw_rdata`
- `irq`  out  1  request pending for the ESP

## Operation
- States:
  - IDLE: `req_ready`=1. On acceptance, latch the offset and go to PENDING.
  - PENDING: `irq`=1.
  - STREAM: `irq`=0; data is forwarded.
- Command is latched on `pw_wstb & pw_wcmd`. The command register clears to NONE on `pw_end`.
- CMD_GET_REQ (0xF8) starts the descriptor read:
  - Descriptor index resets to 0.
  - Bytes 0-3 are FILE_ID, big-endian. Bytes 4-7 are the offset, big-endian. Bytes 8-9 are CHUNK_LEN, big-endian.
  - Index ≥10 returns 0x00.
  - In IDLE every byte returns 0xFF.
  - Each `pw_rstb` advances the index. The index saturates at 10.
- `pw_end` closing a GET_REQ while in PENDING:
  - Index = 10: go to STREAM and clear the byte count.
  - Index < 10: stay in PENDING (ESP retries).
  - In STREAM: no effect; a re-read is allowed.
- CMD_DATA (0xF9): each following `pw_wstb` with `pw_wcmd`=0, in STREAM, with byte count < CHUNK_LEN, is forwarded and increments the count. Otherwise the byte is dropped.
- `pw_end` closing a DATA in STREAM returns to IDLE, even with 0 bytes forwarded. In other states it has no effect.
- Any other command byte: writes are ignored and `pw_rdata`=0xFF.
- Simultaneous events:
  - `pw_end` and `pw_wstb` in the same cycle: the byte is processed first (forwarded if eligible), then the end takes effect.
  - `req_valid` in the same cycle as STREAM→IDLE: not accepted, because `req_ready` is registered and still 0.
- Offset arithmetic is 32-bit, with no modification and no wrap handling.
- Byte count is 16 bits.
- Reset mid-transfer discards the request and returns to IDLE. The next descriptor reflects only newly accepted requests.

## Timing
- Reset values:
  - `req_ready`=1, `irq`=0
  - `resp_valid`=0, `resp_data`=0x00
  - `pw_rdata`=0xFF
  - state IDLE, command NONE, index 0, count 0
- All outputs are registered.
- `irq` rises the cycle after acceptance and falls the cycle after the qualifying `pw_end`.
- `resp_valid`/`resp_data` follow the data `pw_wstb` by 1 cycle. Back-to-back strobes give back-to-back pulses; there is no backpressure.
- `pw_rdata`:
  - Valid the cycle after the GET_REQ command strobe.
  - Updated the cycle after each `pw_rstb`.
  - Stable otherwise.
- `req_ready` goes 0 the cycle after acceptance and 1 the cycle after leaving STREAM.

## Structure
- Shared package holds:
  - the command codes CMD_GET_REQ=8'hF8 and CMD_DATA=8'hF9
  - the state encoding
  - DESC_LEN=10
- Natural sub-module: `fread_desc_mux`, a combinational index→byte selector fed by FILE_ID, the latched offset and CHUNK_LEN.
- All else, including the FSM, command register and counters, lives in one module.

## Test plan
- Reset, then idle → `req_ready`=1, `irq`=0, `pw_rdata`=0xFF, no `resp_valid`.
- `req_offset`=0x00000800 accepted; GET_REQ with 10 `pw_rstb`s, then `pw_end` → bytes DA BB AD 00 00 00 08 00 08 00; `irq` 1→0; state STREAM.
- GET_REQ with only 6 reads, then `pw_end` → `irq` stays 1. A full re-read then moves the block to STREAM.
- DATA with 3 bytes 11 22 33, then `pw_end` → three `resp_valid` pulses each 1 cycle after its strobe, data 11 22 33. `req_ready`=1 the cycle after the end.
- CHUNK_LEN=4, DATA with 6 bytes → exactly 4 pulses; bytes 5-6 dropped.
- DATA bytes in PENDING → no pulses. `rst` asserted in STREAM → all reset values next cycle, and a new request is accepted.

Source files
------------

// File: rtl/fread_bridge_pkg.sv
// Shared constants and state encoding for the ESP file-read bridge.
package fread_bridge_pkg;

   localparam logic [7:0]  CMD_NONE    = 8'h00;
   localparam logic [7:0]  CMD_GET_REQ = 8'hF8;
   localparam logic [7:0]  CMD_DATA    = 8'hF9;
   localparam int unsigned DESC_LEN    = 10;

   typedef enum logic [1:0] {
      StIdle,
      StPending,
      StStream
   } state_e;

endpackage

// File: rtl/fread_bridge_if.sv
// Loader request/response and SPI protocol-wrapper signals of the file-read bridge.
interface fread_bridge_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_offset;
   logic [7:0]  resp_data;
   logic        resp_valid;
   logic [7:0]  pw_wdata;
   logic        pw_wcmd;
   logic        pw_wstb;
   logic        pw_end;
   logic [7:0]  pw_rdata;
   logic        pw_rstb;
   logic        irq;

   // Bridge side
   modport slave (
      input  req_valid, req_offset, pw_wdata, pw_wcmd, pw_wstb, pw_end, pw_rstb,
      output req_ready, resp_data, resp_valid, pw_rdata, irq
   );

   // Loader / wrapper side
   modport master (
      output req_valid, req_offset, pw_wdata, pw_wcmd, pw_wstb, pw_end, pw_rstb,
      input  req_ready, resp_data, resp_valid, pw_rdata, irq
   );
endinterface

// File: rtl/fread_desc_mux.sv
// Selects one byte of the 10-byte big-endian request descriptor by index.
module fread_desc_mux (
   input  logic [3:0]  idx_i,
   input  logic [31:0] file_id_i,
   input  logic [31:0] offset_i,
   input  logic [15:0] chunk_len_i,
   output logic [7:0]  byte_o
);

   // Index 10 and beyond reads as zero
   always_comb begin
      byte_o = 8'h00;
      case (idx_i)
         4'd0:    byte_o = file_id_i[31:24];
         4'd1:    byte_o = file_id_i[23:16];
         4'd2:    byte_o = file_id_i[15:8];
         4'd3:    byte_o = file_id_i[7:0];
         4'd4:    byte_o = offset_i[31:24];
         4'd5:    byte_o = offset_i[23:16];
         4'd6:    byte_o = offset_i[15:8];
         4'd7:    byte_o = offset_i[7:0];
         4'd8:    byte_o = chunk_len_i[15:8];
         4'd9:    byte_o = chunk_len_i[7:0];
         default: byte_o = 8'h00;
      endcase
   end

endmodule

// File: rtl/fread_bridge.sv
// ESP-facing front end for chunked file loads: accepts a loader request, raises irq,
// serves the request descriptor to the ESP and forwards the ESP's data bytes.
module fread_bridge
   import fread_bridge_pkg::*;
#(
   parameter logic [31:0] FILE_ID   = 32'hDABBAD00,
   parameter logic [15:0] CHUNK_LEN = 16'h0800
) (
   input logic           clk,
   input logic           rst,
   fread_bridge_if.slave bus
);

   localparam logic [3:0] DescLen = 4'(DESC_LEN);

   state_e      state_q, state_d;
   logic [7:0]  cmd_q, cmd_d;
   logic [3:0]  idx_q, idx_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] offset_q, offset_d;
   logic        req_ready_q, req_ready_d;
   logic        irq_q, irq_d;
   logic        resp_valid_q, resp_valid_d;
   logic [7:0]  resp_data_q, resp_data_d;
   logic [7:0]  rdata_q, rdata_d;

   logic        cmd_stb;
   logic        dat_stb;
   logic [7:0]  mux_byte;
   logic [7:0]  desc_byte;

   assign cmd_stb = bus.pw_wstb & bus.pw_wcmd;
   assign dat_stb = bus.pw_wstb & ~bus.pw_wcmd;

   // No request is published while idle, so the descriptor reads as all-ones there
   assign desc_byte = (state_q == StIdle) ? 8'hFF : mux_byte;

   fread_desc_mux u_desc_mux (
      .idx_i       (idx_d),
      .file_id_i   (FILE_ID),
      .offset_i    (offset_q),
      .chunk_len_i (CHUNK_LEN),
      .byte_o      (mux_byte)
   );

   // Descriptor index: restarts on GET_REQ, advances per consumed byte, saturates
   always_comb begin
      idx_d = idx_q;
      if (cmd_stb) begin
         if (bus.pw_wdata == CMD_GET_REQ) idx_d = '0;
      end else if (bus.pw_rstb && cmd_q == CMD_GET_REQ && idx_q < DescLen) begin
         idx_d = idx_q + 4'd1;
      end
   end

   // Command register, read data, data forwarding and request FSM
   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      cnt_d        = cnt_q;
      offset_d     = offset_q;
      resp_valid_d = 1'b0;
      resp_data_d  = resp_data_q;
      rdata_d      = rdata_q;

      if (cmd_stb) begin
         cmd_d   = bus.pw_wdata;
         rdata_d = (bus.pw_wdata == CMD_GET_REQ) ? desc_byte : 8'hFF;
      end else if (bus.pw_rstb) begin
         rdata_d = (cmd_q == CMD_GET_REQ) ? desc_byte : 8'hFF;
      end

      if (dat_stb && cmd_q == CMD_DATA && state_q == StStream && cnt_q < CHUNK_LEN) begin
         resp_valid_d = 1'b1;
         resp_data_d  = bus.pw_wdata;
         cnt_d        = cnt_q + 16'd1;
      end

      unique case (state_q)
         StIdle: begin
            if (bus.req_valid && req_ready_q) begin
               offset_d = bus.req_offset;
               state_d  = StPending;
            end
         end
         StPending: begin
            // A short read leaves us pending so the ESP can retry
            if (bus.pw_end && cmd_q == CMD_GET_REQ && idx_q == DescLen) begin
               state_d = StStream;
               cnt_d   = '0;
            end
         end
         StStream: begin
            if (bus.pw_end && cmd_q == CMD_DATA) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // End of transaction wins over a command byte in the same cycle
      if (bus.pw_end) cmd_d = CMD_NONE;

      req_ready_d = (state_d == StIdle);
      irq_d       = (state_d == StPending);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         cmd_q        <= CMD_NONE;
         idx_q        <= '0;
         cnt_q        <= '0;
         offset_q     <= '0;
         req_ready_q  <= 1'b1;
         irq_q        <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= 8'h00;
         rdata_q      <= 8'hFF;
      end else begin
         state_q      <= state_d;
         cmd_q        <= cmd_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         offset_q     <= offset_d;
         req_ready_q  <= req_ready_d;
         irq_q        <= irq_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         rdata_q      <= rdata_d;
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.irq        = irq_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_data  = resp_data_q;
   assign bus.pw_rdata   = rdata_q;

endmodule

// File: tb/tb_fread_bridge.sv
// Bench for fread_bridge: two instances (full chunk and a 4-byte chunk) share stimulus
// and are compared against a transaction-level model of the request/descriptor/data flow.
module tb_fread_bridge;
   import fread_bridge_pkg::*;

   localparam logic [31:0] FileId = 32'hDABBAD00;
   localparam logic [15:0] Chunk0 = 16'h0800;
   localparam logic [15:0] Chunk1 = 16'h0004;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic [31:0] req_offset = '0;
   logic [7:0]  pw_wdata = '0;
   logic        pw_wcmd = 1'b0;
   logic        pw_wstb = 1'b0;
   logic        pw_end = 1'b0;
   logic        pw_rstb = 1'b0;

   always #5 clk = ~clk;

   fread_bridge_if bus0 ();
   fread_bridge_if bus1 ();

   assign bus0.req_valid  = req_valid;
   assign bus0.req_offset = req_offset;
   assign bus0.pw_wdata   = pw_wdata;
   assign bus0.pw_wcmd    = pw_wcmd;
   assign bus0.pw_wstb    = pw_wstb;
   assign bus0.pw_end     = pw_end;
   assign bus0.pw_rstb    = pw_rstb;
   assign bus1.req_valid  = req_valid;
   assign bus1.req_offset = req_offset;
   assign bus1.pw_wdata   = pw_wdata;
   assign bus1.pw_wcmd    = pw_wcmd;
   assign bus1.pw_wstb    = pw_wstb;
   assign bus1.pw_end     = pw_end;
   assign bus1.pw_rstb    = pw_rstb;

   fread_bridge #(.FILE_ID(FileId), .CHUNK_LEN(Chunk0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   fread_bridge #(.FILE_ID(FileId), .CHUNK_LEN(Chunk1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   int checks = 0;
   int failures = 0;

   // Transaction-level model
   bit          m_pend, m_stream;
   logic [31:0] m_off;
   logic [7:0]  m_cmd;
   int          m_idx;
   int          m_cnt   [2];
   bit          e_rv    [2];
   logic [7:0]  e_rd    [2];
   logic [7:0]  e_rdata [2];
   int          pulses  [2];

   function automatic logic [15:0] chunk_of(int k);
      return (k == 0) ? Chunk0 : Chunk1;
   endfunction

   function automatic logic [7:0] desc_byte(int i, logic [31:0] off, logic [15:0] chunk);
      logic [79:0] d;
      d = {FileId, off, chunk};
      if (i >= 10) return 8'h00;
      return d[79 - 8 * i -: 8];
   endfunction

   function automatic logic [7:0] serve(int k);
      if (!m_pend && !m_stream) return 8'hFF;
      return desc_byte(m_idx, m_off, chunk_of(k));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_pend = 0; m_stream = 0; m_off = '0; m_cmd = CMD_NONE; m_idx = 0;
      for (int k = 0; k < 2; k++) begin
         m_cnt[k] = 0; e_rv[k] = 0; e_rd[k] = 8'h00; e_rdata[k] = 8'hFF;
      end
   endtask

   task automatic do_req(input logic [31:0] off);
      req_valid = 1'b1; req_offset = off;
      tick();
      req_valid = 1'b0;
      e_rv = '{0, 0};
      if (!m_pend && !m_stream) begin
         m_pend = 1; m_off = off;
      end
   endtask

   task automatic do_cmd(input logic [7:0] c);
      pw_wcmd = 1'b1; pw_wstb = 1'b1; pw_wdata = c;
      tick();
      pw_wcmd = 1'b0; pw_wstb = 1'b0;
      e_rv = '{0, 0};
      m_cmd = c;
      if (c == CMD_GET_REQ) m_idx = 0;
      for (int k = 0; k < 2; k++) e_rdata[k] = (c == CMD_GET_REQ) ? serve(k) : 8'hFF;
   endtask

   task automatic do_read();
      pw_rstb = 1'b1;
      tick();
      pw_rstb = 1'b0;
      e_rv = '{0, 0};
      if (m_cmd == CMD_GET_REQ && m_idx < 10) m_idx++;
      for (int k = 0; k < 2; k++) e_rdata[k] = (m_cmd == CMD_GET_REQ) ? serve(k) : 8'hFF;
   endtask

   // req_valid is left as the caller set it, to probe acceptance during the end cycle
   task automatic do_end();
      bit was_idle;
      was_idle = !m_pend && !m_stream;
      pw_end = 1'b1;
      tick();
      pw_end = 1'b0;
      e_rv = '{0, 0};
      if (was_idle && req_valid) begin
         m_pend = 1; m_off = req_offset;
      end else if (m_cmd == CMD_GET_REQ && m_pend && m_idx == 10) begin
         m_pend = 0; m_stream = 1; m_cnt = '{0, 0};
      end else if (m_cmd == CMD_DATA && m_stream) begin
         m_stream = 0;
      end
      m_cmd = CMD_NONE;
   endtask

   task automatic do_data(input logic [7:0] b);
      pw_wcmd = 1'b0; pw_wstb = 1'b1; pw_wdata = b;
      tick();
      pw_wstb = 1'b0;
      for (int k = 0; k < 2; k++) begin
         e_rv[k] = 0;
         if (m_cmd == CMD_DATA && m_stream && m_cnt[k] < int'(chunk_of(k))) begin
            e_rv[k] = 1; e_rd[k] = b; m_cnt[k]++;
         end
      end
   endtask

   task automatic goto_stream(input logic [31:0] off);
      do_req(off);
      do_cmd(CMD_GET_REQ);
      repeat (10) do_read();
      do_end();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      model_reset();
      tick();
      checks++;
      if (bus0.req_ready !== 1'b1 || bus0.irq !== 1'b0 || bus1.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_hs: ready=%b irq=%b exp ready=1 irq=0", bus0.req_ready, bus0.irq);
      end
      checks++;
      if (bus0.pw_rdata !== 8'hFF || bus1.pw_rdata !== 8'hFF) begin
         failures++;
         $display("FAIL reset_rdata: got %h/%h exp ff", bus0.pw_rdata, bus1.pw_rdata);
      end
      checks++;
      if (bus0.resp_valid !== 1'b0 || bus0.resp_data !== 8'h00 || bus1.resp_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_resp: valid=%b data=%h exp 0/00", bus0.resp_valid, bus0.resp_data);
      end
   endtask

   task automatic test_get_req();
      logic [7:0] lit [10];
      lit = '{8'hDA, 8'hBB, 8'hAD, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h08, 8'h00};
      do_req(32'h0000_0800);
      checks++;
      if (bus0.irq !== 1'b1 || bus0.req_ready !== 1'b0) begin
         failures++;
         $display("FAIL accept: irq=%b ready=%b exp 1/0", bus0.irq, bus0.req_ready);
      end
      do_cmd(CMD_GET_REQ);
      for (int i = 0; i < 11; i++) begin
         if (i > 0) do_read();
         checks++;
         if (bus0.pw_rdata !== e_rdata[0] || bus1.pw_rdata !== e_rdata[1]) begin
            failures++;
            $display("FAIL desc_byte%0d: got %h/%h exp %h/%h", i, bus0.pw_rdata,
                     bus1.pw_rdata, e_rdata[0], e_rdata[1]);
         end
         if (i < 10) begin
            checks++;
            if (bus0.pw_rdata !== lit[i]) begin
               failures++;
               $display("FAIL desc_lit%0d: got %h exp %h", i, bus0.pw_rdata, lit[i]);
            end
         end
      end
      do_end();
      checks++;
      if (bus0.irq !== 1'b0 || bus0.req_ready !== 1'b0 || m_stream != 1) begin
         failures++;
         $display("FAIL to_stream: irq=%b ready=%b exp 0/0", bus0.irq, bus0.req_ready);
      end
   endtask

   task automatic test_data();
      logic [7:0] bytes [3];
      bytes = '{8'h11, 8'h22, 8'h33};
      do_cmd(CMD_DATA);
      for (int i = 0; i < 3; i++) begin
         do_data(bytes[i]);
         checks++;
         if (bus0.resp_valid !== 1'b1 || bus0.resp_data !== bytes[i] ||
             bus1.resp_valid !== e_rv[1] || bus1.resp_data !== e_rd[1]) begin
            failures++;
            $display("FAIL data%0d: got %b/%h exp 1/%h", i, bus0.resp_valid,
                     bus0.resp_data, bytes[i]);
         end
      end
      do_end();
      checks++;
      if (bus0.resp_valid !== 1'b0 || bus0.req_ready !== 1'b1 || bus0.irq !== 1'b0) begin
         failures++;
         $display("FAIL data_end: valid=%b ready=%b irq=%b exp 0/1/0", bus0.resp_valid,
                  bus0.req_ready, bus0.irq);
      end
   endtask

   task automatic test_partial_read();
      int n;
      do_req($urandom);
      do_cmd(CMD_GET_REQ);
      n = $urandom_range(0, 9);
      repeat (n) do_read();
      checks++;
      if (bus0.pw_rdata !== e_rdata[0] || bus1.pw_rdata !== e_rdata[1]) begin
         failures++;
         $display("FAIL partial_byte: got %h exp %h", bus0.pw_rdata, e_rdata[0]);
      end
      do_end();
      checks++;
      if (bus0.irq !== 1'b1 || bus1.irq !== 1'b1) begin
         failures++;
         $display("FAIL partial_irq: got %b exp 1 after %0d reads", bus0.irq, n);
      end
      do_cmd(CMD_GET_REQ);
      for (int i = 0; i < 10; i++) begin
         do_read();
         checks++;
         if (bus0.pw_rdata !== e_rdata[0] || bus1.pw_rdata !== e_rdata[1]) begin
            failures++;
            $display("FAIL reread%0d: got %h exp %h", i, bus0.pw_rdata, e_rdata[0]);
         end
      end
      do_end();
      checks++;
      if (bus0.irq !== 1'b0 || bus0.req_ready !== 1'b0) begin
         failures++;
         $display("FAIL reread_stream: irq=%b ready=%b exp 0/0", bus0.irq, bus0.req_ready);
      end
   endtask

   // Back-to-back data bytes; the 4-byte-chunk instance must drop everything past 4
   task automatic test_back_to_back();
      int n;
      n = $urandom_range(5, 9);
      pulses = '{0, 0};
      do_cmd(CMD_DATA);
      for (int i = 0; i < n; i++) begin
         do_data(8'($urandom));
         for (int k = 0; k < 2; k++) begin
            if ((k == 0 ? bus0.resp_valid : bus1.resp_valid) === 1'b1) pulses[k]++;
         end
         checks++;
         if (bus0.resp_valid !== e_rv[0] || bus0.resp_data !== e_rd[0] ||
             bus1.resp_valid !== e_rv[1] || bus1.resp_data !== e_rd[1]) begin
            failures++;
            $display("FAIL b2b%0d: got %b%h/%b%h exp %b%h/%b%h", i, bus0.resp_valid,
                     bus0.resp_data, bus1.resp_valid, bus1.resp_data, e_rv[0], e_rd[0],
                     e_rv[1], e_rd[1]);
         end
      end
      checks++;
      if (pulses[0] != n || pulses[1] != 4) begin
         failures++;
         $display("FAIL pulse_count: got %0d/%0d exp %0d/4", pulses[0], pulses[1], n);
      end
   endtask

   // Request presented while DATA closes: not accepted that cycle, accepted the next
   task automatic test_req_on_close();
      req_valid = 1'b1; req_offset = $urandom;
      do_end();
      checks++;
      if (bus0.req_ready !== 1'b1 || bus0.irq !== 1'b0 || m_pend) begin
         failures++;
         $display("FAIL close_req: ready=%b irq=%b exp 1/0", bus0.req_ready, bus0.irq);
      end
      do_req(req_offset);
      checks++;
      if (bus0.irq !== 1'b1 || bus0.req_ready !== 1'b0) begin
         failures++;
         $display("FAIL close_req_next: irq=%b ready=%b exp 1/0", bus0.irq, bus0.req_ready);
      end
   endtask

   task automatic test_pending_data();
      do_cmd(CMD_DATA);
      for (int i = 0; i < 3; i++) begin
         do_data(8'($urandom));
         checks++;
         if (bus0.resp_valid !== 1'b0 || bus1.resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL pend_data%0d: valid=%b exp 0", i, bus0.resp_valid);
         end
      end
      do_end();
      checks++;
      if (bus0.irq !== 1'b1) begin
         failures++;
         $display("FAIL pend_end_irq: got %b exp 1", bus0.irq);
      end
   endtask

   task automatic test_stream_reset();
      logic [31:0] off;
      // Finish the pending request, then reset mid-stream
      do_cmd(CMD_GET_REQ);
      repeat (10) do_read();
      do_end();
      do_cmd(CMD_DATA);
      do_data(8'hA5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      checks++;
      if (bus0.req_ready !== 1'b1 || bus0.irq !== 1'b0 || bus0.pw_rdata !== 8'hFF ||
          bus0.resp_valid !== 1'b0 || bus0.resp_data !== 8'h00) begin
         failures++;
         $display("FAIL mid_reset: ready=%b irq=%b rdata=%h valid=%b data=%h",
                  bus0.req_ready, bus0.irq, bus0.pw_rdata, bus0.resp_valid, bus0.resp_data);
      end
      off = $urandom;
      goto_stream(off);
      checks++;
      if (m_stream != 1 || bus0.irq !== 1'b0 || bus0.req_ready !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_stream: irq=%b ready=%b", bus0.irq, bus0.req_ready);
      end
      do_cmd(CMD_GET_REQ);
      for (int i = 1; i < 10; i++) begin
         do_read();
         checks++;
         if (bus0.pw_rdata !== desc_byte(i, off, Chunk0) || bus1.pw_rdata !== e_rdata[1]) begin
            failures++;
            $display("FAIL new_desc%0d: got %h exp %h", i, bus0.pw_rdata,
                     desc_byte(i, off, Chunk0));
         end
      end
      do_cmd(CMD_DATA);
      do_data(8'h5A);
      checks++;
      if (bus0.resp_valid !== 1'b1 || bus0.resp_data !== 8'h5A) begin
         failures++;
         $display("FAIL post_reset_data: got %b/%h exp 1/5a", bus0.resp_valid, bus0.resp_data);
      end
      do_end();
   endtask

   initial begin
      test_reset();
      test_get_req();
      test_data();
      test_partial_read();
      test_back_to_back();
      test_req_on_close();
      test_pending_data();
      test_stream_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
